// File: rtl/fetch_pc_unit_pkg.sv
// Shared types and constants for the fetch PC unit and its prediction queue.
package fetch_pc_unit_pkg;

    localparam int unsigned INSTR_BYTES      = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // One in-flight fetch: where it was fetched and what the BTB predicted for it.
    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
    } pred_entry_t;

    function automatic logic [31:0] seq_pc(input logic [31:0] cur_pc);
        return cur_pc + 32'(INSTR_BYTES);
    endfunction

endpackage

// File: rtl/fetch_pc_unit_pred_fifo.sv
// In-order queue of prediction records, pushed at fetch and popped as each
// instruction reaches EXE. Clear empties it on a redirect.
module pred_fifo
    import fetch_pc_unit_pkg::*;
#(
    parameter int QDEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  pred_entry_t push_data,
    input  logic        pop,
    input  logic        clear,
    output logic        full,
    output logic        empty,
    output pred_entry_t head_data
);

    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = PTR_W + 1;

    pred_entry_t        mem [QDEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               do_push;
    logic               do_pop;

    always_comb begin
        empty   = (count == '0);
        full    = (count == CNT_W'(QDEPTH));
        do_pop  = pop & ~empty;
        // A full queue still takes a push when the head leaves in the same cycle.
        do_push = push & (~full | do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries data only; validity lives entirely in the pointers and count.
    always_ff @(posedge clk) begin
        if (do_push && !clear && !rst) mem[wr_ptr] <= push_data;
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch PC generator: BTB-steered next-PC selection, prediction tracking and
// mispredict redirect when the instruction resolves in EXE.
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          QDEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        btb_hit,
    input  logic [31:0] btb_addr,
    input  logic        exe_valid,
    input  logic        exe_branch,
    input  logic        exe_taken,
    input  logic [31:0] exe_target,
    output logic [31:0] pc,
    output logic        pred_taken,
    output logic        flush,
    output logic        q_full,
    output logic [31:0] mispred_cnt
);

    pred_entry_t head;
    pred_entry_t push_entry;
    logic        q_empty;
    logic        pop_ok;
    logic        act_taken;
    logic        mispred;
    logic        fetch_ok;
    logic [31:0] redirect_pc;
    logic [31:0] fetch_next;

    always_comb begin
        pop_ok      = exe_valid & ~q_empty & ~rst;
        act_taken   = exe_branch & exe_taken;
        mispred     = 1'b0;
        if (pop_ok) begin
            mispred = (head.taken != act_taken) |
                      (head.taken & exe_taken & (head.target != exe_target));
        end
        redirect_pc = act_taken ? exe_target : seq_pc(head.pc);
        fetch_ok    = ~rst & ~stall & (~q_full | pop_ok) & ~mispred;
        fetch_next  = btb_hit ? btb_addr : seq_pc(pc);
    end

    always_comb begin
        push_entry        = '0;
        push_entry.pc     = pc;
        push_entry.taken  = btb_hit;
        push_entry.target = btb_addr;
    end

    assign flush      = mispred;
    assign pred_taken = btb_hit;

    pred_fifo #(
        .QDEPTH(QDEPTH)
    ) u_pred_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fetch_ok),
        .push_data (push_entry),
        .pop       (pop_ok),
        .clear     (mispred),
        .full      (q_full),
        .empty     (q_empty),
        .head_data (head)
    );

    // PC register: redirect outranks the predicted/sequential fetch path.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (mispred) begin
            pc <= redirect_pc;
        end else if (fetch_ok) begin
            pc <= fetch_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mispred_cnt <= '0;
        end else if (mispred) begin
            mispred_cnt <= mispred_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scenario bench for fetch_pc_unit with a prediction-queue scoreboard model.
module tb_fetch_pc_unit;
    import fetch_pc_unit_pkg::*;

    localparam int          QDEPTH   = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst, stall, btb_hit, exe_valid, exe_branch, exe_taken;
    logic [31:0] btb_addr, exe_target;
    logic [31:0] pc, mispred_cnt;
    logic        pred_taken, flush, q_full;

    int errors = 0;
    int checks = 0;

    pred_entry_t sb[$];
    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    logic        exp_flush;

    fetch_pc_unit #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
        .clk(clk), .rst(rst), .stall(stall), .btb_hit(btb_hit), .btb_addr(btb_addr),
        .exe_valid(exe_valid), .exe_branch(exe_branch), .exe_taken(exe_taken),
        .exe_target(exe_target), .pc(pc), .pred_taken(pred_taken), .flush(flush),
        .q_full(q_full), .mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs and advance the reference model to the post-edge state.
    task automatic set_in(input logic r, input logic s, input logic h, input logic [31:0] a,
                          input logic ev, input logic eb, input logic et, input logic [31:0] t);
        pred_entry_t e, ne;
        logic pop, mis, act, full, acc;
        logic [31:0] redir;
        rst = r; stall = s; btb_hit = h; btb_addr = a;
        exe_valid = ev; exe_branch = eb; exe_taken = et; exe_target = t;
        exp_flush = 1'b0;
        if (r) begin
            sb.delete();
            m_pc  = RESET_PC;
            m_cnt = '0;
        end else begin
            pop = ev && (sb.size() != 0);
            mis = 1'b0;
            redir = '0;
            if (pop) begin
                e   = sb[0];
                act = eb && et;
                mis = (e.taken != act) || (e.taken && et && (e.target != t));
                redir = act ? t : e.pc + 32'd4;
            end
            exp_flush = mis;
            if (mis) begin
                sb.delete();
                m_pc  = redir;
                m_cnt = m_cnt + 32'd1;
            end else begin
                full = (sb.size() == QDEPTH);
                acc  = !s && (!full || pop);
                if (pop) void'(sb.pop_front());
                if (acc) begin
                    ne.pc = m_pc; ne.taken = h; ne.target = a;
                    sb.push_back(ne);
                    m_pc = h ? a : m_pc + 32'd4;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        set_in(1, 0, 0, 0, 0, 0, 0, 0); tick();
    endtask

    task automatic idle(input logic s);
        set_in(0, s, 0, 0, 0, 0, 0, 0); tick();
    endtask

    task automatic test_reset();
        set_in(1, 1, 1, 32'h44, 1, 1, 1, 32'h88);
        #1;
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush: got %b exp 0", flush); end
        tick();
        set_in(1, 0, 0, 0, 0, 0, 0, 0); tick();
        checks++; if (pc !== RESET_PC) begin errors++; $display("FAIL reset_pc: got %h exp %h", pc, RESET_PC); end
        checks++; if (q_full !== 1'b0) begin errors++; $display("FAIL reset_qfull: got %b exp 0", q_full); end
        checks++; if (mispred_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt: got %0d exp 0", mispred_cnt); end
    endtask

    task automatic test_sequential();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            idle(0);
            checks++;
            if (pc !== 32'((i + 1) * 4) || pc !== m_pc) begin
                errors++; $display("FAIL seq_pc%0d: got %h exp %h", i, pc, 32'((i + 1) * 4));
            end
        end
        checks++; if (q_full !== 1'b0) begin errors++; $display("FAIL seq_qfull3: got %b exp 0", q_full); end
        idle(0);
        checks++; if (pc !== 32'h10) begin errors++; $display("FAIL fill_pc: got %h exp 10", pc); end
        checks++; if (q_full !== 1'b1 || (sb.size() != QDEPTH)) begin errors++; $display("FAIL fill_qfull: got %b exp 1", q_full); end
        idle(0);
        checks++; if (pc !== 32'h10) begin errors++; $display("FAIL full_hold: got %h exp 10", pc); end
        set_in(0, 0, 0, 0, 1, 0, 0, 0);
        #1;
        checks++; if (flush !== exp_flush) begin errors++; $display("FAIL popfull_flush: got %b exp %b", flush, exp_flush); end
        tick();
        checks++; if (pc !== 32'h14) begin errors++; $display("FAIL popfull_pc: got %h exp 14", pc); end
        checks++; if (q_full !== 1'b1) begin errors++; $display("FAIL popfull_qfull: got %b exp 1", q_full); end
        idle(1);
        checks++; if (pc !== 32'h14) begin errors++; $display("FAIL stall_hold: got %h exp 14", pc); end
        set_in(0, 1, 0, 0, 1, 0, 0, 0); tick();
        checks++; if (q_full !== 1'b0 || pc !== 32'h14) begin errors++; $display("FAIL stall_pop: got full=%b pc=%h exp full=0 pc=14", q_full, pc); end
    endtask

    task automatic test_btb_mispredict();
        do_reset();
        idle(0); idle(0);
        set_in(0, 0, 1, 32'h100, 0, 0, 0, 0);
        #1;
        checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL pred_taken: got %b exp 1", pred_taken); end
        tick();
        checks++; if (pc !== 32'h100) begin errors++; $display("FAIL btb_pc: got %h exp 100", pc); end
        checks++;
        if (sb.size() != 3 || sb[2].pc != 32'h8 || sb[2].taken != 1'b1 || sb[2].target != 32'h100) begin
            errors++; $display("FAIL btb_entry: got size %0d exp entry {8,1,100}", sb.size());
        end
        for (int i = 0; i < 2; i++) begin
            set_in(0, 1, 0, 0, 1, 0, 0, 0);
            #1;
            checks++; if (flush !== 1'b0) begin errors++; $display("FAIL okpop%0d_flush: got %b exp 0", i, flush); end
            tick();
        end
        set_in(0, 1, 0, 0, 1, 1, 0, 0);
        #1;
        checks++; if (flush !== 1'b1 || flush !== exp_flush) begin errors++; $display("FAIL nt_flush: got %b exp 1", flush); end
        tick();
        checks++; if (pc !== 32'hC) begin errors++; $display("FAIL nt_pc: got %h exp c", pc); end
        checks++; if (mispred_cnt !== 32'd1 || mispred_cnt !== m_cnt) begin errors++; $display("FAIL nt_cnt: got %0d exp 1", mispred_cnt); end
        set_in(0, 1, 0, 0, 1, 1, 1, 32'h999);
        #1;
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL empty_pop_flush: got %b exp 0", flush); end
        tick();
        checks++; if (pc !== 32'hC || mispred_cnt !== 32'd1) begin errors++; $display("FAIL empty_pop: got pc=%h cnt=%0d exp pc=c cnt=1", pc, mispred_cnt); end
    endtask

    task automatic test_redirect();
        do_reset();
        set_in(0, 0, 1, 32'h20, 0, 0, 0, 0); tick();
        set_in(0, 0, 0, 0, 1, 1, 1, 32'h20);
        #1;
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL taken_ok_flush: got %b exp 0", flush); end
        tick();
        checks++; if (pc !== 32'h24) begin errors++; $display("FAIL taken_ok_pc: got %h exp 24", pc); end
        set_in(0, 1, 0, 0, 1, 1, 1, 32'h40);
        #1;
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL nt2t_flush: got %b exp 1", flush); end
        tick();
        checks++; if (pc !== 32'h40 || pc !== m_pc) begin errors++; $display("FAIL nt2t_pc: got %h exp 40", pc); end
        set_in(0, 0, 1, 32'h100, 0, 0, 0, 0); tick();
        set_in(0, 1, 0, 0, 1, 1, 1, 32'h200);
        #1;
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL tgt_flush: got %b exp 1", flush); end
        tick();
        checks++; if (pc !== 32'h200) begin errors++; $display("FAIL tgt_pc: got %h exp 200", pc); end
        checks++; if (mispred_cnt !== 32'd2) begin errors++; $display("FAIL tgt_cnt: got %0d exp 2", mispred_cnt); end
    endtask

    task automatic test_wrap_and_reset_mid();
        do_reset();
        set_in(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0); tick();
        idle(0);
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL wrap_pc: got %h exp 0", pc); end
        set_in(0, 1, 0, 0, 1, 0, 0, 0);
        #1;
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL t2nt_flush: got %b exp 1", flush); end
        tick();
        checks++; if (pc !== 32'h4 || mispred_cnt !== 32'd1) begin errors++; $display("FAIL t2nt: got pc=%h cnt=%0d exp pc=4 cnt=1", pc, mispred_cnt); end
        set_in(0, 0, 1, 32'h80, 0, 0, 0, 0); tick();
        set_in(1, 0, 0, 0, 1, 0, 0, 0);
        #1;
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL rstmid_flush: got %b exp 0", flush); end
        tick();
        checks++; if (pc !== RESET_PC || mispred_cnt !== 32'd0 || q_full !== 1'b0) begin
            errors++; $display("FAIL rstmid_state: got pc=%h cnt=%0d full=%b exp pc=%h cnt=0 full=0", pc, mispred_cnt, q_full, RESET_PC);
        end
        set_in(0, 1, 0, 0, 1, 0, 0, 0);
        #1;
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL rstmid_empty: got %b exp 0", flush); end
        tick();
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; btb_hit = 1'b0; btb_addr = '0;
        exe_valid = 1'b0; exe_branch = 1'b0; exe_taken = 1'b0; exe_target = '0;
        m_pc = RESET_PC; m_cnt = '0; exp_flush = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_sequential();
        test_btb_mispredict();
        test_redirect();
        test_wrap_and_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
